// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared sizes and burst-reader state type for mem_sync users.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 16;
    localparam int MEM_DEPTH = 256;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_burst_rd_skid.sv
`default_nettype none
// ============================================================================
//  Module      : mem_burst_rd_skid
//  Description : Two-entry output buffer carrying read data plus a last flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_burst_rd_skid #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_push_last,
    input  logic              i_pop,
    output logic [1:0]        o_count,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_head_data,
    output logic              o_head_last
);

    logic [DATA_W-1:0] r_data [2];
    logic [1:0]        r_last;
    logic              r_wp;
    logic              r_rp;
    logic [1:0]        r_count;
    logic              w_pop;

    assign w_pop = i_pop && (r_count != 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data[0] <= '0;
            r_data[1] <= '0;
            r_last    <= 2'b00;
            r_wp      <= 1'b0;
            r_rp      <= 1'b0;
            r_count   <= 2'd0;
        end else begin
            if (i_push) begin
                r_data[r_wp] <= i_push_data;
                r_last[r_wp] <= i_push_last;
                r_wp         <= ~r_wp;
            end
            if (w_pop) begin
                r_rp <= ~r_rp;
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Head only moves on a pop, so data holds steady while stalled.
    assign o_count     = r_count;
    assign o_valid     = (r_count != 2'd0);
    assign o_head_data = r_data[r_rp];
    assign o_head_last = r_last[r_rp];

endmodule
`default_nettype wire

// File: rtl/mem_burst_rd.sv
`default_nettype none
// ============================================================================
//  Module      : mem_burst_rd
//  Description : Burst reader streaming words from a synchronous memory.
//                Define MEM_BURST_RD_WRAP_EN to let bursts wrap past the top
//                address; otherwise such requests are rejected with err.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_burst_rd #(
    parameter int ADDR_W = mem_pkg::ADDR_W,
    parameter int DATA_W = mem_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    import mem_pkg::*;

    localparam logic [ADDR_W:0]   c_len_one  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] c_addr_one = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_hold;
    logic [ADDR_W:0]   r_rem;
    logic              r_inflight;
    logic              r_inflight_last;
    logic              r_done;

    logic              w_req;
    logic              w_req_zero;
    logic              w_over;
    logic              w_accept;
    logic              w_issue;
    logic              w_pop;
    logic              w_final_pop;
    logic [2:0]        w_load;
    logic [1:0]        w_count;
    logic              w_valid;
    logic              w_head_last;
    logic [DATA_W-1:0] w_head_data;

    assign w_req      = (r_state == ST_IDLE) && start;
    assign w_req_zero = w_req && (len == '0);

`ifdef MEM_BURST_RD_WRAP_EN
    assign w_over = 1'b0;
    assign err    = 1'b0;
`else
    localparam logic [ADDR_W+1:0] c_span = {2'b01, {ADDR_W{1'b0}}};

    logic [ADDR_W+1:0] w_end;
    logic              r_err;

    assign w_end  = {2'b00, start_addr} + {1'b0, len};
    assign w_over = (w_end > c_span);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_req && !w_req_zero && w_over;
        end
    end

    assign err = r_err;
`endif

    assign w_accept    = w_req && !w_req_zero && !w_over;
    assign w_pop       = w_valid && out_ready;
    assign w_final_pop = w_pop && w_head_last;

    // Words held or still coming back from memory; a pop this cycle frees a slot.
    assign w_load = {1'b0, w_count} + {2'b00, r_inflight};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_issue && (r_rem == c_len_one)) begin
                    w_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_final_pop) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy    = (r_state != ST_IDLE);
        w_issue = 1'b0;
        if (r_state == ST_RUN) begin
            w_issue = (w_load < (3'd2 + {2'b00, w_pop}));
        end
        mem_addr = w_issue ? r_addr : r_hold;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr          <= '0;
            r_hold          <= '0;
            r_rem           <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_done          <= w_req_zero || ((r_state == ST_DRAIN) && w_final_pop);
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_rem == c_len_one);
            if (w_accept) begin
                r_addr <= start_addr;
                r_rem  <= len;
            end else if (w_issue) begin
                r_addr <= r_addr + c_addr_one;
                r_rem  <= r_rem - c_len_one;
                r_hold <= r_addr;
            end
        end
    end

    mem_burst_rd_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (r_inflight),
        .i_push_data (mem_rd),
        .i_push_last (r_inflight_last),
        .i_pop       (w_pop),
        .o_count     (w_count),
        .o_valid     (w_valid),
        .o_head_data (w_head_data),
        .o_head_last (w_head_last)
    );

    assign done      = r_done;
    assign mem_wen   = 1'b0;
    assign mem_wd    = '0;
    assign out_valid = w_valid;
    assign out_data  = w_head_data;
    assign out_last  = w_valid && w_head_last;

endmodule
`default_nettype wire

// File: tb/tb_mem_burst_rd.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_burst_rd
//  Description : Randomized self-checking bench for mem_burst_rd.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_burst_rd;

`ifdef MEM_BURST_RD_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b1;
    logic        start      = 1'b0;
    logic [7:0]  start_addr = 8'h00;
    logic [8:0]  len        = 9'd0;
    logic        out_ready  = 1'b0;
    logic [15:0] mem_rd     = 16'h0000;
    logic        busy, done, err, mem_wen, out_valid, out_last;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wd, out_data;

    logic [15:0] mem [256];

    int checks = 0;
    int passes = 0;
    int wen_bad = 0;

    logic [15:0] ob_data[$];
    logic        ob_last[$];
    int          ob_cyc[$];
    int          ob_done[$];
    int          ob_err[$];
    int          ob_first;
    int          stab_bad;
    int          last_bad;
    bit          ob_busy;
    bit          ob_timeout;

    logic [15:0] ex_data[$];
    logic        ex_last[$];
    bit          ex_err;
    bit          ex_done;

    mem_burst_rd #(.ADDR_W(8), .DATA_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .mem_addr   (mem_addr),
        .mem_wen    (mem_wen),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_rd <= mem[mem_addr];

    always @(negedge clk) begin
        if (mem_wen !== 1'b0 || mem_wd !== 16'h0000) wen_bad++;
    end

    // Reference: a burst is just the words mem[(a+i) mod 256] in order.
    task automatic model(input logic [7:0] a, input int l);
        ex_data.delete();
        ex_last.delete();
        ex_err  = 1'b0;
        ex_done = 1'b0;
        if (l == 0) begin
            ex_done = 1'b1;
        end else if (!WRAP && (int'(a) + l > 256)) begin
            ex_err = 1'b1;
        end else begin
            for (int i = 0; i < l; i++) begin
                ex_data.push_back(16'hA000 + 16'((int'(a) + i) % 256));
                ex_last.push_back(i == l - 1);
            end
            ex_done = 1'b1;
        end
    endtask

    function automatic logic ready_for(input int mode, input int c);
        case (mode)
            0:       return 1'b1;
            1:       return (c % 3) == 0;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // Drives one request (start in cycle 0) and records everything observed.
    task automatic run_burst(input logic [7:0] a, input logic [8:0] l, input int mode, input int hold);
        int          quiet = 0;
        logic        pstall = 1'b0;
        logic [15:0] pdata = 16'h0000;
        ob_data.delete(); ob_last.delete(); ob_cyc.delete();
        ob_done.delete(); ob_err.delete();
        ob_first = -1; stab_bad = 0; last_bad = 0; ob_busy = 1'b0; ob_timeout = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            start      = (c < hold);
            start_addr = a;
            len        = l;
            out_ready  = ready_for(mode, c);
            #1;
            if (out_valid && ob_first < 0) ob_first = c;
            if (pstall && (!out_valid || out_data !== pdata)) stab_bad++;
            if (out_last && !out_valid) last_bad++;
            if (busy) ob_busy = 1'b1;
            if (out_valid && out_ready) begin
                ob_data.push_back(out_data);
                ob_last.push_back(out_last);
                ob_cyc.push_back(c);
            end
            if (done) ob_done.push_back(c);
            if (err) ob_err.push_back(c);
            pstall = out_valid && !out_ready;
            pdata  = out_data;
            if (!busy && c >= hold) quiet++; else quiet = 0;
            if (quiet >= 3) begin
                ob_timeout = 1'b0;
                break;
            end
        end
        start     = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, err, out_valid, out_last, mem_wen} !== 6'b0)
            $display("FAIL reset_flags: got %b required 000000", {busy, done, err, out_valid, out_last, mem_wen});
        else passes++;
        checks++;
        if (mem_addr !== 8'h00) $display("FAIL reset_mem_addr: got %h required 00", mem_addr);
        else passes++;
        checks++;
        if (mem_wd !== 16'h0000) $display("FAIL reset_mem_wd: got %h required 0000", mem_wd);
        else passes++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, out_valid} !== 2'b00) $display("FAIL reset_release: got %b required 00", {busy, out_valid});
        else passes++;
    endtask

    task automatic test_basic();
        model(8'h10, 4);
        run_burst(8'h10, 9'd4, 0, 1);
        checks++;
        if (ob_timeout) $display("FAIL basic_timeout: got timeout required finish");
        else passes++;
        checks++;
        if (ob_first !== 3) $display("FAIL basic_latency: got %0d required 3", ob_first);
        else passes++;
        checks++;
        if (ob_data.size() !== ex_data.size()) $display("FAIL basic_count: got %0d required %0d", ob_data.size(), ex_data.size());
        else passes++;
        for (int i = 0; i < ex_data.size() && i < ob_data.size(); i++) begin
            checks++;
            if ({ob_data[i], ob_last[i], ob_cyc[i]} !== {ex_data[i], ex_last[i], 3 + i})
                $display("FAIL basic_beat%0d: got %h/%b@%0d required %h/%b@%0d", i, ob_data[i], ob_last[i], ob_cyc[i], ex_data[i], ex_last[i], 3 + i);
            else passes++;
        end
        checks++;
        if (ob_done.size() !== 1 || ob_done[0] !== 7) $display("FAIL basic_done: got %0d pulses first@%0d required 1@7", ob_done.size(), (ob_done.size() > 0) ? ob_done[0] : -1);
        else passes++;
        checks++;
        if (ob_err.size() !== 0 || last_bad !== 0) $display("FAIL basic_err_last: got err=%0d stray_last=%0d required 0/0", ob_err.size(), last_bad);
        else passes++;
    endtask

    task automatic test_stall();
        model(8'h10, 4);
        run_burst(8'h10, 9'd4, 1, 1);
        checks++;
        if (ob_timeout || ob_first !== 3) $display("FAIL stall_start: got timeout=%0d first=%0d required 0/3", ob_timeout, ob_first);
        else passes++;
        checks++;
        if (ob_data.size() !== ex_data.size()) $display("FAIL stall_count: got %0d required %0d", ob_data.size(), ex_data.size());
        else passes++;
        for (int i = 0; i < ex_data.size() && i < ob_data.size(); i++) begin
            checks++;
            if ({ob_data[i], ob_last[i]} !== {ex_data[i], ex_last[i]})
                $display("FAIL stall_beat%0d: got %h/%b required %h/%b", i, ob_data[i], ob_last[i], ex_data[i], ex_last[i]);
            else passes++;
        end
        checks++;
        if (stab_bad !== 0) $display("FAIL stall_stable: got %0d changes required 0", stab_bad);
        else passes++;
        checks++;
        if (ob_done.size() !== 1 || ob_cyc.size() == 0 || ob_done[0] !== ob_cyc[ob_cyc.size()-1] + 1)
            $display("FAIL stall_done: got %0d pulses required 1 right after last beat", ob_done.size());
        else passes++;
    endtask

    task automatic test_wrap();
        logic [7:0] a_list [2];
        a_list[0] = 8'hFE;
        a_list[1] = 8'hFC;
        for (int k = 0; k < 2; k++) begin
            model(a_list[k], 4);
            run_burst(a_list[k], 9'd4, 0, 1);
            checks++;
            if (ob_timeout) $display("FAIL wrap%0d_timeout: got timeout required finish", k);
            else passes++;
            checks++;
            if (ob_data.size() !== ex_data.size()) $display("FAIL wrap%0d_count: got %0d required %0d", k, ob_data.size(), ex_data.size());
            else passes++;
            for (int i = 0; i < ex_data.size() && i < ob_data.size(); i++) begin
                checks++;
                if ({ob_data[i], ob_last[i]} !== {ex_data[i], ex_last[i]})
                    $display("FAIL wrap%0d_beat%0d: got %h/%b required %h/%b", k, i, ob_data[i], ob_last[i], ex_data[i], ex_last[i]);
                else passes++;
            end
            checks++;
            if (ex_err && (ob_err.size() !== 1 || ob_err[0] !== 1 || ob_done.size() !== 0 || ob_busy))
                $display("FAIL wrap%0d_reject: got err=%0d done=%0d busy=%0d required err@1 only", k, ob_err.size(), ob_done.size(), ob_busy);
            else if (!ex_err && (ob_err.size() !== 0 || ob_done.size() !== 1))
                $display("FAIL wrap%0d_accept: got err=%0d done=%0d required 0/1", k, ob_err.size(), ob_done.size());
            else passes++;
        end
    endtask

    task automatic test_len_zero();
        model(8'h33, 0);
        run_burst(8'h33, 9'd0, 0, 1);
        checks++;
        if (ob_done.size() !== 1 || ob_done[0] !== 1) $display("FAIL len0_done: got %0d pulses required 1@1", ob_done.size());
        else passes++;
        checks++;
        if (ob_first !== -1 || ob_busy || ob_err.size() !== 0)
            $display("FAIL len0_quiet: got first=%0d busy=%0d err=%0d required -1/0/0", ob_first, ob_busy, ob_err.size());
        else passes++;
    endtask

    task automatic test_start_held();
        model(8'h20, 8);
        run_burst(8'h20, 9'd8, 0, 6);
        checks++;
        if (ob_timeout || ob_data.size() !== 8 || ob_done.size() !== 1)
            $display("FAIL held_once: got timeout=%0d beats=%0d done=%0d required 0/8/1", ob_timeout, ob_data.size(), ob_done.size());
        else passes++;
        for (int i = 0; i < ex_data.size() && i < ob_data.size(); i++) begin
            checks++;
            if ({ob_data[i], ob_last[i]} !== {ex_data[i], ex_last[i]})
                $display("FAIL held_beat%0d: got %h/%b required %h/%b", i, ob_data[i], ob_last[i], ex_data[i], ex_last[i]);
            else passes++;
        end
    endtask

    task automatic test_reset_mid_burst();
        int nb = 0;
        int stale = 0;
        bit reached = 1'b0;
        @(negedge clk);
        start = 1'b1; start_addr = 8'h40; len = 9'd8; out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (out_valid && out_ready) nb++;
            if (nb == 3) begin
                reached = 1'b1;
                break;
            end
            @(negedge clk);
            start = 1'b0;
        end
        start = 1'b0;
        checks++;
        if (!reached) $display("FAIL rstmid_beats: got %0d beats required 3", nb);
        else passes++;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, err, out_valid, out_last, mem_addr} !== 13'b0)
            $display("FAIL rstmid_outputs: got %b/%h required 0", {busy, done, err, out_valid, out_last}, mem_addr);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            if (out_valid || busy || done) stale++;
        end
        checks++;
        if (stale !== 0) $display("FAIL rstmid_stale: got %0d active cycles required 0", stale);
        else passes++;
        model(8'h80, 5);
        run_burst(8'h80, 9'd5, 2, 1);
        checks++;
        if (ob_timeout || ob_data.size() !== ex_data.size())
            $display("FAIL rstmid_new_count: got timeout=%0d beats=%0d required 0/%0d", ob_timeout, ob_data.size(), ex_data.size());
        else passes++;
        for (int i = 0; i < ex_data.size() && i < ob_data.size(); i++) begin
            checks++;
            if ({ob_data[i], ob_last[i]} !== {ex_data[i], ex_last[i]})
                $display("FAIL rstmid_beat%0d: got %h/%b required %h/%b", i, ob_data[i], ob_last[i], ex_data[i], ex_last[i]);
            else passes++;
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            logic [7:0] a;
            int         l;
            a = 8'($urandom_range(0, 255));
            l = $urandom_range(1, 24);
            model(a, l);
            run_burst(a, 9'(l), 2, 1);
            checks++;
            if (ob_timeout || ob_data.size() !== ex_data.size())
                $display("FAIL rand%0d_count: a=%h l=%0d got timeout=%0d beats=%0d required 0/%0d", n, a, l, ob_timeout, ob_data.size(), ex_data.size());
            else passes++;
            for (int i = 0; i < ex_data.size() && i < ob_data.size(); i++) begin
                checks++;
                if ({ob_data[i], ob_last[i]} !== {ex_data[i], ex_last[i]})
                    $display("FAIL rand%0d_beat%0d: got %h/%b required %h/%b", n, i, ob_data[i], ob_last[i], ex_data[i], ex_last[i]);
                else passes++;
            end
            checks++;
            if (ob_err.size() !== int'(ex_err) || ob_done.size() !== int'(ex_done) || stab_bad !== 0 || last_bad !== 0)
                $display("FAIL rand%0d_ctrl: got err=%0d done=%0d unstable=%0d stray_last=%0d required %0d/%0d/0/0",
                         n, ob_err.size(), ob_done.size(), stab_bad, last_bad, ex_err, ex_done);
            else passes++;
        end
    endtask

    task automatic test_mem_wen();
        checks++;
        if (wen_bad !== 0) $display("FAIL mem_wen_zero: got %0d bad cycles required 0", wen_bad);
        else passes++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'hA000 + 16'(i);
        test_reset();
        test_basic();
        test_stall();
        test_wrap();
        test_len_zero();
        test_start_held();
        test_reset_mid_burst();
        test_random();
        test_mem_wen();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got no completion required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/mem_burst_rd.md
MEM_BURST_RD -- requirements
Module: mem_burst_rd

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 8, memory address width; DATA_W, default 16, memory word width.
REQ-002 Ports SHALL be:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  burst request, sampled in IDLE only
- start_addr  in  ADDR_W  first word address
- len  in  ADDR_W+1  word count, 0..256
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse at burst end
- err  out  1  one-cycle pulse on rejected request
- mem_addr  out  ADDR_W  address to synchronous memory
- mem_wen  out  1  memory write enable, constant 0
- mem_wd  out  DATA_W  memory write data, constant 0
- mem_rd  in  DATA_W  memory read data, valid one cycle after mem_addr
- out_data  out  DATA_W  stream data
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready
- out_last  out  1  marks the final beat

Function
REQ-003 States SHALL be IDLE, RUN and DRAIN.
REQ-004 IDLE with start=1 and len>0 SHALL latch start_addr and len and enter RUN next cycle.
REQ-005 IDLE with start=1 and len=0 SHALL pulse done on the next cycle, emit no beats and remain in IDLE.
REQ-006 start SHALL be ignored while busy=1.
REQ-007 In RUN, a read SHALL issue in any cycle where (buffered + in-flight - popped) < 2; popped = out_valid & out_ready.
REQ-008 Each issued read SHALL present the current address on mem_addr, then increment the address modulo 2^ADDR_W and decrement the remaining count.
REQ-009 mem_rd SHALL be captured into the 2-entry output buffer exactly one cycle after its issue; no captured word SHALL ever be dropped.
REQ-010 The first out_valid SHALL assert 3 cycles after the sampling edge of start.
REQ-011 Sustained throughput SHALL be one beat per cycle while out_ready=1.
REQ-012 out_data and out_valid SHALL hold stable while out_valid=1 and out_ready=0.
REQ-013 RUN SHALL go to DRAIN after the last issue; DRAIN SHALL go to IDLE when the final beat handshakes.
REQ-014 done SHALL pulse in the cycle after the final handshake.
REQ-015 out_last SHALL be 1 only with the final beat.
REQ-016 busy SHALL be 1 in RUN and DRAIN.
REQ-017 mem_addr SHALL hold its last value when no read issues.

Reset
REQ-018 rst_n=0 SHALL immediately force IDLE, empty the buffer and discard in-flight reads.
REQ-019 During reset, busy, done, err, out_valid, out_last, mem_addr, mem_wen and mem_wd SHALL be 0.
REQ-020 After reset deasserts mid-burst, no stale beat SHALL appear.

Configuration
REQ-021 Macro MEM_BURST_RD_WRAP_EN defined: bursts with start_addr+len > 2^ADDR_W SHALL wrap from the top address to 0; err SHALL be constant 0.
REQ-022 Macro MEM_BURST_RD_WRAP_EN undefined: such a request SHALL be rejected with a one-cycle err pulse on the next cycle, no beats, no done, and the block SHALL stay in IDLE.

Structure
REQ-023 Package mem_pkg SHALL hold ADDR_W, DATA_W, MEM_DEPTH (=256) and the state enum type; it is shared with mem_sync users.
REQ-024 The 2-entry buffer SHALL be sub-module mem_burst_rd_skid (push, pop, count, data, last flag).

Verification
REQ-025 Memory holds mem[i]=16'hA000+i. Test: start_addr=8'h10, len=4, out_ready=1 -> beats A010..A013 on consecutive cycles; first beat 3 cycles after start; out_last on A013; done one cycle later.
REQ-026 Same burst with out_ready toggled 1,0,0,1,... -> same 4 values in order, none lost or duplicated; data stable while stalled.
REQ-027 start_addr=8'hFE, len=4 -> with the macro defined: A0FE, A0FF, A000, A001; without it: err pulse and no beats.
REQ-028 len=0 -> done pulses after 1 cycle, out_valid stays 0. start held high during a burst -> exactly one burst.
REQ-029 rst_n low for 1 cycle mid-burst (len=8, after 3 beats) -> outputs 0 at once; after release, no beats until a new start, then the new burst is correct.
REQ-030 All cycles -> mem_wen=0.
